// File: rtl/pipemem_iox.sv
// MEM-stage memory block: word-addressed data RAM with asynchronous read plus an
// IO window of output registers, synchronised input ports and a sticky change-status register.
module pipemem_iox #(
    parameter int ADDR_BITS = 5,
    parameter int NUM_OUT   = 2,
    parameter int NUM_IN    = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  mwmem,
    input  logic                  mrmem,
    input  logic [31:0]           malu,
    input  logic [31:0]           mb,
    input  logic [32*NUM_IN-1:0]  in_ports,
    output logic [32*NUM_OUT-1:0] out_ports,
    output logic [31:0]           mmo,
    output logic [NUM_IN-1:0]     in_event
);
    localparam int DEPTH = 2 ** ADDR_BITS;

    logic                 io;
    logic [4:0]           ridx;
    logic [ADDR_BITS-1:0] widx;
    logic                 status_sel;
    logic                 status_w1c;
    logic                 status_cor;

    logic [31:0]       ram [DEPTH];
    logic [31:0]       out_reg   [NUM_OUT];
    logic [31:0]       sync1_reg [NUM_IN];
    logic [31:0]       sync2_reg [NUM_IN];
    logic [31:0]       prev_reg  [NUM_IN];
    logic [NUM_IN-1:0] flag_reg;
    logic [NUM_IN-1:0] flag_next;
    logic [NUM_OUT-1:0] out_wr;
    logic [31:0]       mmo_next;
    logic              unused_ok;

    assign io         = malu[7];
    assign ridx       = malu[6:2];
    assign widx       = malu[ADDR_BITS+1:2];
    assign status_sel = io && (ridx == 5'd31);
    // A simultaneous read+write of status behaves purely as a write.
    assign status_w1c = status_sel && mwmem;
    assign status_cor = status_sel && mrmem && !mwmem;
    assign unused_ok  = ^{malu[31:8], malu[1:0]};

    // RAM contents survive reset; stores presented while reset is high are dropped.
    always_ff @(posedge clock) begin
        if (!reset && mwmem && !io) begin
            ram[widx] <= mb;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OUT; gi++) begin : g_out
            assign out_wr[gi]                = io && mwmem && (ridx == 5'(gi));
            assign out_ports[32*gi +: 32]    = out_reg[gi];
        end
        for (gi = 0; gi < NUM_IN; gi++) begin : g_in
            // A fresh change outranks any clear landing on the same edge.
            assign flag_next[gi] = (sync2_reg[gi] != prev_reg[gi]) |
                                   (flag_reg[gi] & ~((status_w1c & mb[gi]) | status_cor));
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                out_reg[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (out_wr[k]) begin
                    out_reg[k] <= mb;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_IN; k++) begin
                sync1_reg[k] <= '0;
                sync2_reg[k] <= '0;
                prev_reg[k]  <= '0;
            end
            flag_reg <= '0;
        end else begin
            for (int k = 0; k < NUM_IN; k++) begin
                sync1_reg[k] <= in_ports[32*k +: 32];
                sync2_reg[k] <= sync1_reg[k];
                prev_reg[k]  <= sync2_reg[k];
            end
            flag_reg <= flag_next;
        end
    end

    // Load path is purely combinational; same-cycle stores are not forwarded.
    always_comb begin
        mmo_next = '0;
        if (!io) begin
            mmo_next = ram[widx];
        end else begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (ridx == 5'(k)) begin
                    mmo_next = out_reg[k];
                end
            end
            for (int k = 0; k < NUM_IN; k++) begin
                if (ridx == 5'(16 + k)) begin
                    mmo_next = sync2_reg[k];
                end
            end
            if (ridx == 5'd31) begin
                mmo_next = 32'(flag_reg);
            end
        end
    end

    assign mmo      = mmo_next;
    assign in_event = flag_reg;

endmodule

// File: tb/tb_pipemem_iox.sv
// Directed bench for pipemem_iox: stimulus queues expected values, a negedge monitor
// pops and compares them against the live DUT outputs.
module tb_pipemem_iox;
    logic        clock = 1'b0;
    logic        reset;
    logic        mwmem;
    logic        mrmem;
    logic [31:0] malu;
    logic [31:0] mb;
    logic [63:0] in_ports;
    logic [63:0] out_ports;
    logic [31:0] mmo;
    logic [1:0]  in_event;

    localparam int SEL_MMO  = 0;
    localparam int SEL_OUT0 = 1;
    localparam int SEL_OUT1 = 2;
    localparam int SEL_EVT  = 3;

    string       q_name [$];
    int          q_sel  [$];
    logic [31:0] q_exp  [$];
    int          errors = 0;
    int          checks = 0;

    pipemem_iox #(.ADDR_BITS(5), .NUM_OUT(2), .NUM_IN(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .mwmem     (mwmem),
        .mrmem     (mrmem),
        .malu      (malu),
        .mb        (mb),
        .in_ports  (in_ports),
        .out_ports (out_ports),
        .mmo       (mmo),
        .in_event  (in_event)
    );

    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_val(input int sel, input string name, input logic [31:0] val);
        q_sel.push_back(sel);
        q_name.push_back(name);
        q_exp.push_back(val);
    endtask

    task automatic drive(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        mwmem = w;
        mrmem = r;
        malu  = a;
        mb    = d;
    endtask

    // Monitor: compares every queued expectation at the falling edge.
    initial begin
        forever begin
            @(negedge clock);
            while (q_exp.size() > 0) begin
                logic [31:0] act;
                logic [31:0] exp_v;
                string       nm;
                int          sel;
                sel   = q_sel.pop_front();
                nm    = q_name.pop_front();
                exp_v = q_exp.pop_front();
                case (sel)
                    SEL_OUT0: act = out_ports[31:0];
                    SEL_OUT1: act = out_ports[63:32];
                    SEL_EVT:  act = {30'b0, in_event};
                    default:  act = mmo;
                endcase
                checks++;
                if (act !== exp_v) begin
                    errors++;
                    $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp_v);
                end else begin
                    $display("ok   %s: 0x%08h", nm, act);
                end
            end
        end
    end

    initial begin
        reset    = 1'b1;
        in_ports = '0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        cyc();
        // Reset state
        drive(1'b0, 1'b0, 32'h84, 32'h0);
        expect_val(SEL_MMO,  "rst_mmo_io", 32'h0);
        expect_val(SEL_OUT0, "rst_out0",   32'h0);
        expect_val(SEL_OUT1, "rst_out1",   32'h0);
        expect_val(SEL_EVT,  "rst_evt",    32'h0);
        cyc();
        reset = 1'b0;

        // RAM store/load
        drive(1'b1, 1'b0, 32'h00, 32'h11111111); cyc();
        drive(1'b1, 1'b0, 32'h04, 32'h44444444); cyc();
        drive(1'b1, 1'b0, 32'h7C, 32'hDEADBEEF); cyc();
        drive(1'b0, 1'b0, 32'h7C, 32'h0);
        expect_val(SEL_MMO, "ram_7c", 32'hDEADBEEF); cyc();
        drive(1'b0, 1'b0, 32'h00, 32'h0);
        expect_val(SEL_MMO, "ram_00", 32'h11111111); cyc();
        drive(1'b1, 1'b0, 32'h7C, 32'hCAFEF00D);
        expect_val(SEL_MMO, "ram_noforward", 32'hDEADBEEF); cyc();
        drive(1'b0, 1'b0, 32'h7F, 32'h0);
        expect_val(SEL_MMO, "ram_lowbits_ignored", 32'hCAFEF00D); cyc();

        // Output registers
        drive(1'b1, 1'b0, 32'h84, 32'h12345678); cyc();
        drive(1'b0, 1'b0, 32'h84, 32'h0);
        expect_val(SEL_OUT1, "out1_written", 32'h12345678);
        expect_val(SEL_OUT0, "out0_untouched", 32'h0);
        expect_val(SEL_MMO,  "load_84", 32'h12345678); cyc();
        drive(1'b0, 1'b0, 32'h04, 32'h0);
        expect_val(SEL_MMO, "ram_04_unchanged", 32'h44444444); cyc();
        drive(1'b1, 1'b0, 32'h88, 32'h77777777); cyc();
        drive(1'b0, 1'b0, 32'h88, 32'h0);
        expect_val(SEL_MMO, "unmapped_reads_0", 32'h0); cyc();
        drive(1'b1, 1'b0, 32'h80, 32'hA0A0A0A0); cyc();
        drive(1'b0, 1'b0, 32'h80, 32'h0);
        expect_val(SEL_OUT0, "out0_written", 32'hA0A0A0A0); cyc();

        // Input synchroniser and event
        in_ports[31:0] = 32'hA5;
        drive(1'b0, 1'b0, 32'hC0, 32'h0);
        expect_val(SEL_MMO, "in0_preE", 32'h0); cyc();            // edge E
        expect_val(SEL_MMO, "in0_afterE", 32'h0);
        expect_val(SEL_EVT, "evt_afterE", 32'h0); cyc();          // E+1
        expect_val(SEL_MMO, "in0_afterE1", 32'hA5);
        expect_val(SEL_EVT, "evt_afterE1", 32'h0); cyc();         // E+2
        expect_val(SEL_EVT, "evt_afterE2", 32'h1); cyc();

        // Raise flag 1 as well
        in_ports[63:32] = 32'h1;
        cyc(); cyc(); cyc();
        drive(1'b0, 1'b0, 32'hC4, 32'h0);
        expect_val(SEL_EVT, "evt_both", 32'h3);
        expect_val(SEL_MMO, "in1_read", 32'h1); cyc();

        // Status clear rules
        drive(1'b1, 1'b0, 32'hFC, 32'h1);
        expect_val(SEL_MMO, "status_prewrite", 32'h3); cyc();
        drive(1'b0, 1'b0, 32'hFC, 32'h0);
        expect_val(SEL_EVT, "w1c_evt", 32'h2); cyc();
        drive(1'b0, 1'b1, 32'hFC, 32'h0);
        expect_val(SEL_MMO, "cor_read", 32'h2); cyc();
        drive(1'b0, 1'b0, 32'hFC, 32'h0);
        expect_val(SEL_EVT, "cor_cleared", 32'h0); cyc();

        // Set vs clear-on-read collision on port 1
        in_ports[63:32] = 32'h2;
        cyc(); cyc();                                              // E, E+1
        drive(1'b0, 1'b1, 32'hFC, 32'h0);
        expect_val(SEL_MMO, "collide_pre", 32'h0); cyc();         // E+2: set wins
        drive(1'b0, 1'b0, 32'hFC, 32'h0);
        expect_val(SEL_EVT, "collide_set_wins", 32'h2); cyc();
        drive(1'b1, 1'b1, 32'hFC, 32'h0); cyc();                  // write of 0: no clear
        drive(1'b0, 1'b0, 32'hFC, 32'h0);
        expect_val(SEL_EVT, "rw_is_write", 32'h2); cyc();
        drive(1'b1, 1'b1, 32'hFC, 32'h2); cyc();
        drive(1'b0, 1'b0, 32'hFC, 32'h0);
        expect_val(SEL_EVT, "rw_w1c", 32'h0); cyc();

        // Mid-operation reset
        in_ports[31:0] = 32'h5A;
        cyc(); cyc(); cyc();
        expect_val(SEL_EVT, "pre_reset_evt", 32'h1); cyc();
        in_ports = '0;
        drive(1'b1, 1'b0, 32'h80, 32'hFFFFFFFF);
        reset = 1'b1;
        expect_val(SEL_OUT0, "async_rst_out0", 32'h0);
        expect_val(SEL_EVT,  "async_rst_evt", 32'h0); cyc();
        expect_val(SEL_OUT0, "rst_store_dropped", 32'h0);
        expect_val(SEL_EVT,  "rst_evt_held", 32'h0); cyc();
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h80, 32'h0);
        cyc(); cyc(); cyc();
        expect_val(SEL_EVT, "post_rst_no_flag", 32'h0);
        expect_val(SEL_MMO, "post_rst_out0", 32'h0); cyc();
        drive(1'b0, 1'b0, 32'h7C, 32'h0);
        expect_val(SEL_MMO, "ram_survives_reset", 32'hCAFEF00D); cyc();

        @(negedge clock);
        #1;
        if (q_exp.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL queue_drain: got %0d pending want 0", q_exp.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
